arch_state_dump: RTL and testbench

Synthesizable end-of-run architectural state reader for the out-of-order CPU. It sits beside `CPU` and consumes its debug exports: `done`, the retire stream, the flattened PRF and the flattened front/back RATs. On termination it walks x0..x(ARCH_REGS-1), resolves each register through the selected RAT into the PRF, and emits one register per valid/ready beat. It also keeps cycle and retire statistics, so a bench or FPGA wrapper needs no hierarchical peeking.

---
 rtl/parameter_pkg.sv | 9 +
 rtl/typedef_pkg.sv | 8 +
 rtl/flat_index_mux.sv | 22 ++
 rtl/arch_state_dump.sv | 163 ++++++++++++++++
 tb/tb_arch_state_dump.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/parameter_pkg.sv
// Default sizing shared by the architectural state dump and its surroundings.
package parameter_pkg;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ARCH_REGS  = 32;
   localparam int unsigned PHY_REGS   = 64;
   localparam int unsigned PHY_WIDTH  = 6;
   localparam int unsigned MAX_CYCLES = 6000;
endpackage

// File: rtl/typedef_pkg.sv
// Shared type definitions for the architectural state dump.
package typedef_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DUMP     = 2'd1,
      FINISHED = 2'd2
   } dump_state_t;
endpackage

// File: rtl/flat_index_mux.sv
// Selects one WIDTH-bit entry out of a flattened vector of ENTRIES entries.
module flat_index_mux #(
   parameter int unsigned ENTRIES   = 64,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEL_WIDTH = 6
) (
   input  logic [ENTRIES*WIDTH-1:0] flat,
   input  logic [SEL_WIDTH-1:0]     sel,
   output logic [WIDTH-1:0]         entry_c
);

   // Compare-and-select keeps out-of-range selects at zero instead of slicing past the vector.
   always_comb begin
      entry_c = '0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
         if (sel == SEL_WIDTH'(j)) begin
            entry_c = flat[j*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/arch_state_dump.sv
// End-of-run architectural register reader: waits for done/timeout, snapshots a RAT,
// then streams every architectural register through the PRF on a valid/ready port.
module arch_state_dump
   import typedef_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = parameter_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = parameter_pkg::DATA_WIDTH,
   parameter int unsigned ARCH_REGS  = parameter_pkg::ARCH_REGS,
   parameter int unsigned PHY_REGS   = parameter_pkg::PHY_REGS,
   parameter int unsigned PHY_WIDTH  = parameter_pkg::PHY_WIDTH,
   parameter int unsigned MAX_CYCLES = parameter_pkg::MAX_CYCLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            done,
   input  logic                            retire_valid_reg,
   input  logic [ADDR_WIDTH-1:0]           retire_addr_reg,
   input  logic [PHY_REGS*DATA_WIDTH-1:0]  PRF_data_out,
   input  logic [PHY_WIDTH*ARCH_REGS-1:0]  front_rat_out,
   input  logic [PHY_WIDTH*ARCH_REGS-1:0]  back_rat_out,
   output logic                            dump_valid,
   input  logic                            dump_ready,
   output logic [$clog2(ARCH_REGS)-1:0]    dump_idx,
   output logic [DATA_WIDTH-1:0]           dump_data,
   output logic                            dump_src_front,
   output logic                            dump_last,
   output logic                            dump_complete,
   output logic [31:0]                     n_cycles,
   output logic [31:0]                     n_retired,
   output logic [ADDR_WIDTH-1:0]           last_retire_addr
);

   localparam int unsigned IDX_WIDTH = $clog2(ARCH_REGS);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ARCH_REGS - 1);
   localparam logic [31:0] TIMEOUT = 32'(MAX_CYCLES);

   dump_state_t                         state_q, state_d;
   logic [IDX_WIDTH-1:0]                idx_q, idx_d;
   logic [PHY_WIDTH*ARCH_REGS-1:0]      snap_q, snap_d;
   logic                                src_front_q, src_front_d;
   logic [31:0]                         n_cycles_q, n_cycles_d;
   logic [31:0]                         n_retired_q, n_retired_d;
   logic [ADDR_WIDTH-1:0]               last_addr_q, last_addr_d;
   logic                                valid_q, valid_d;
   logic                                last_q, last_d;
   logic                                complete_q, complete_d;
   logic [PHY_WIDTH-1:0]                phy_tag_c;
   logic [DATA_WIDTH-1:0]               prf_entry_c;

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         idx_q       <= '0;
         snap_q      <= '0;
         src_front_q <= 1'b0;
         n_cycles_q  <= '0;
         n_retired_q <= '0;
         last_addr_q <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         complete_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         src_front_q <= src_front_d;
         n_cycles_q  <= n_cycles_d;
         n_retired_q <= n_retired_d;
         last_addr_q <= last_addr_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         complete_q  <= complete_d;
      end
   end

   // Next-state, counters and next-output values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      src_front_d = src_front_q;
      n_cycles_d  = n_cycles_q;
      n_retired_d = n_retired_q;
      last_addr_d = last_addr_q;

      case (state_q)
         RUN: begin
            if (n_cycles_q != 32'hFFFF_FFFF) begin
               n_cycles_d = n_cycles_q + 32'd1;
            end
            if (retire_valid_reg) begin
               last_addr_d = retire_addr_reg;
               if (n_retired_q != 32'hFFFF_FFFF) begin
                  n_retired_d = n_retired_q + 32'd1;
               end
            end
            // A normal finish outranks a timeout seen in the same cycle.
            if (done) begin
               src_front_d = 1'b1;
               snap_d      = front_rat_out;
               idx_d       = '0;
               state_d     = DUMP;
            end else if (n_cycles_q >= TIMEOUT) begin
               src_front_d = 1'b0;
               snap_d      = back_rat_out;
               idx_d       = '0;
               state_d     = DUMP;
            end
         end
         DUMP: begin
            if (valid_q && dump_ready) begin
               idx_d = idx_q + IDX_WIDTH'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = FINISHED;
               end
            end
         end
         FINISHED: begin
            state_d = FINISHED;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      valid_d    = (state_d == DUMP);
      last_d     = (state_d == DUMP) && (idx_d == LAST_IDX);
      complete_d = (state_d == FINISHED);
   end

   flat_index_mux #(
      .ENTRIES   (ARCH_REGS),
      .WIDTH     (PHY_WIDTH),
      .SEL_WIDTH (IDX_WIDTH)
   ) u_rat_read (
      .flat    (snap_q),
      .sel     (idx_q),
      .entry_c (phy_tag_c)
   );

   flat_index_mux #(
      .ENTRIES   (PHY_REGS),
      .WIDTH     (DATA_WIDTH),
      .SEL_WIDTH (PHY_WIDTH)
   ) u_prf_read (
      .flat    (PRF_data_out),
      .sel     (phy_tag_c),
      .entry_c (prf_entry_c)
   );

   // PRF is read live; data is forced to zero whenever no beat is offered.
   assign dump_data        = valid_q ? prf_entry_c : '0;
   assign dump_valid       = valid_q;
   assign dump_idx         = idx_q;
   assign dump_src_front   = src_front_q;
   assign dump_last        = last_q;
   assign dump_complete    = complete_q;
   assign n_cycles         = n_cycles_q;
   assign n_retired        = n_retired_q;
   assign last_retire_addr = last_addr_q;

endmodule

// File: tb/tb_arch_state_dump.sv
// Directed and randomized bench for arch_state_dump against an array-based reference model.
module tb_arch_state_dump;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned AR = 32;
   localparam int unsigned PR = 64;
   localparam int unsigned PW = 6;
   localparam int unsigned MC = 100;
   localparam int unsigned IW = $clog2(AR);

   logic             clk = 1'b0;
   logic             rst;
   logic             done;
   logic             retire_valid_reg;
   logic [AW-1:0]    retire_addr_reg;
   logic [PR*DW-1:0] prf_flat;
   logic [PW*AR-1:0] front_flat;
   logic [PW*AR-1:0] back_flat;
   logic             dump_valid;
   logic             dump_ready;
   logic [IW-1:0]    dump_idx;
   logic [DW-1:0]    dump_data;
   logic             dump_src_front;
   logic             dump_last;
   logic             dump_complete;
   logic [31:0]      n_cycles;
   logic [31:0]      n_retired;
   logic [AW-1:0]    last_retire_addr;

   // Reference model state: plain arrays of the CPU exports plus the expected snapshot.
   logic [DW-1:0] prf_m   [PR];
   logic [PW-1:0] front_m [AR];
   logic [PW-1:0] back_m  [AR];
   logic [PW-1:0] snap_m  [AR];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      prf_flat   = '0;
      front_flat = '0;
      back_flat  = '0;
      for (int j = 0; j < PR; j++) prf_flat[j*DW +: DW] = prf_m[j];
      for (int i = 0; i < AR; i++) begin
         front_flat[i*PW +: PW] = front_m[i];
         back_flat[i*PW +: PW]  = back_m[i];
      end
   end

   arch_state_dump #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ARCH_REGS  (AR),
      .PHY_REGS   (PR),
      .PHY_WIDTH  (PW),
      .MAX_CYCLES (MC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .done             (done),
      .retire_valid_reg (retire_valid_reg),
      .retire_addr_reg  (retire_addr_reg),
      .PRF_data_out     (prf_flat),
      .front_rat_out    (front_flat),
      .back_rat_out     (back_flat),
      .dump_valid       (dump_valid),
      .dump_ready       (dump_ready),
      .dump_idx         (dump_idx),
      .dump_data        (dump_data),
      .dump_src_front   (dump_src_front),
      .dump_last        (dump_last),
      .dump_complete    (dump_complete),
      .n_cycles         (n_cycles),
      .n_retired        (n_retired),
      .last_retire_addr (last_retire_addr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},    64'(dump_valid), 64'(0));
      check({tag, "_idx"},      64'(dump_idx), 64'(0));
      check({tag, "_data"},     64'(dump_data), 64'(0));
      check({tag, "_src"},      64'(dump_src_front), 64'(0));
      check({tag, "_last"},     64'(dump_last), 64'(0));
      check({tag, "_complete"}, 64'(dump_complete), 64'(0));
      check({tag, "_ncyc"},     64'(n_cycles), 64'(0));
      check({tag, "_nret"},     64'(n_retired), 64'(0));
      check({tag, "_addr"},     64'(last_retire_addr), 64'(0));
   endtask

   task automatic randomize_state();
      for (int j = 0; j < PR; j++) prf_m[j] = $urandom;
      for (int i = 0; i < AR; i++) begin
         front_m[i] = PW'($urandom_range(0, PR - 1));
         back_m[i]  = PW'($urandom_range(0, PR - 1));
      end
   endtask

   task automatic scramble_rats();
      for (int i = 0; i < AR; i++) begin
         front_m[i] = PW'($urandom_range(0, PR - 1));
         back_m[i]  = PW'($urandom_range(0, PR - 1));
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      done = 1'b0;
      retire_valid_reg = 1'b0;
      retire_addr_reg = '0;
      dump_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   // Walk the dump beat by beat; mode 0 = ready high, 1 = ready 0/1 alternating, 2 = random.
   // stop_at >= 0 returns as soon as that beat has been checked.
   task automatic run_dump(input int mode, input logic exp_front, input int stop_at,
                           input logic scramble, output int cycles);
      int k;
      k = 0;
      cycles = 0;
      while (k < AR && cycles < 300) begin
         check("beat_valid", 64'(dump_valid), 64'(1));
         check("beat_idx",   64'(dump_idx), 64'(k));
         check("beat_data",  64'(dump_data), 64'(prf_m[snap_m[k]]));
         check("beat_src",   64'(dump_src_front), 64'(exp_front));
         check("beat_last",  64'(dump_last), 64'(k == AR - 1));
         check("beat_cmpl",  64'(dump_complete), 64'(0));
         if (k == stop_at) return;
         case (mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = cycles[0];
            default: dump_ready = 1'($urandom_range(0, 1));
         endcase
         if (scramble) scramble_rats();
         tick();
         cycles++;
         if (dump_ready) k++;
      end
      check("dump_beats_in_bound", 64'(k), 64'(AR));
      dump_ready = 1'b0;
      check("end_valid",    64'(dump_valid), 64'(0));
      check("end_complete", 64'(dump_complete), 64'(1));
   endtask

   task automatic take_snapshot(input logic front);
      for (int i = 0; i < AR; i++) snap_m[i] = front ? front_m[i] : back_m[i];
   endtask

   initial begin
      int cyc;
      int wait_cyc;
      logic [AW-1:0] addrs [3];
      addrs[0] = 32'h0000_0000;
      addrs[1] = 32'h0000_0004;
      addrs[2] = 32'h0000_0008;
      for (int j = 0; j < PR; j++) prf_m[j] = '0;
      for (int i = 0; i < AR; i++) begin
         front_m[i] = '0;
         back_m[i]  = '0;
         snap_m[i]  = '0;
      end

      // Counters: ten cycles with three retire pulses.
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         retire_valid_reg = (c < 3);
         retire_addr_reg  = (c < 3) ? addrs[c] : 32'hFFFF_FFF0;
         tick();
      end
      retire_valid_reg = 1'b0;
      check("run_ncyc",  64'(n_cycles), 64'(10));
      check("run_nret",  64'(n_retired), 64'(3));
      check("run_addr",  64'(last_retire_addr), 64'h8);
      check("run_valid", 64'(dump_valid), 64'(0));

      // Normal finish at cycle 20 through the front RAT, ready held high.
      randomize_state();
      for (int i = 0; i < AR; i++) begin
         front_m[i]  = PW'(i + 32);
         prf_m[i+32] = 32'h1000 + 32'(i);
      end
      for (int c = 0; c < 9; c++) tick();
      check("pre_done_ncyc", 64'(n_cycles), 64'(19));
      check("pre_done_valid", 64'(dump_valid), 64'(0));
      done = 1'b1;
      take_snapshot(1'b1);
      tick();
      done = 1'b0;
      retire_valid_reg = 1'b1;
      retire_addr_reg  = 32'hDEAD_BEE0;
      run_dump(0, 1'b1, -1, 1'b0, cyc);
      retire_valid_reg = 1'b0;
      check("done_cycles", 64'(cyc), 64'(AR));
      check("frozen_nret", 64'(n_retired), 64'(3));
      check("frozen_addr", 64'(last_retire_addr), 64'h8);
      tick();
      check("finished_sticky", 64'(dump_complete), 64'(1));

      // Timeout through the back RAT.
      apply_reset();
      for (int i = 0; i < AR; i++) back_m[i] = PW'(i);
      for (int j = 0; j < PR; j++) prf_m[j] = 32'(j * 4);
      take_snapshot(1'b0);
      wait_cyc = 0;
      while (!dump_valid && wait_cyc < 200) begin
         tick();
         wait_cyc++;
      end
      check("timeout_edge", 64'(wait_cyc), 64'(MC + 1));
      run_dump(2, 1'b0, -1, 1'b1, cyc);

      // done and timeout together; ready alternating with RATs rewritten during the dump.
      apply_reset();
      randomize_state();
      for (int c = 0; c < MC; c++) tick();
      check("coinc_ncyc", 64'(n_cycles), 64'(MC));
      check("coinc_valid", 64'(dump_valid), 64'(0));
      done = 1'b1;
      take_snapshot(1'b1);
      tick();
      done = 1'b0;
      run_dump(1, 1'b1, -1, 1'b1, cyc);
      check("toggle_cycles", 64'(cyc), 64'(2 * AR));

      // Reset mid-dump at idx 7, then a fresh dump from idx 0.
      apply_reset();
      randomize_state();
      for (int c = 0; c < int'($urandom_range(1, 40)); c++) tick();
      done = 1'b1;
      take_snapshot(1'b1);
      tick();
      done = 1'b0;
      run_dump(0, 1'b1, 7, 1'b0, cyc);
      rst = 1'b1;
      tick();
      check_reset_outputs("abort");
      rst = 1'b0;
      randomize_state();
      tick();
      done = 1'b1;
      take_snapshot(1'b1);
      tick();
      done = 1'b0;
      run_dump(2, 1'b1, -1, 1'b1, cyc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
